// File: rtl/vga_pkg.sv
// Shared VGA timing presets, coordinate width and small helpers for the scan generator.
package vga_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COORD_MAX = 1 << COORD_W;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          hs_pol;
        bit          vs_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
        hs_pol: POL_ACTIVE_LOW, vs_pol: POL_ACTIVE_LOW
    };

    localparam vga_timing_t VGA_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6, v_bp: 23,
        hs_pol: POL_ACTIVE_HIGH, vs_pol: POL_ACTIVE_HIGH
    };

    // Raw (pre-polarity) timing bits carried through the sync delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bits_t;

    // True when pos lies in [lo, lo+len); done in 32 bits so a window ending at 1024 still works.
    function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        int unsigned p;
        p = 32'(pos);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enable gated shift register; also exposes the stage feeding the last one.
module vga_sync_delay #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_pre_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i];
        end
        if (ce_i) begin
            stage_d[0] = d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

    // With a single stage the "previous" stage is the undelayed input itself.
    if (DEPTH == 1) begin : g_pre_direct
        assign q_pre_o = d_i;
    end else begin : g_pre_stage
        assign q_pre_o = stage_q[DEPTH-2];
    end

endmodule

// File: rtl/vga_scan_gen.sv
// Parametrised VGA scan generator: pixel strobe, x/y scan, latency-matched sync/DE/colour,
// and frame/vblank event reporting.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
    parameter int unsigned H_FP     = VGA_640X480_60.h_fp,
    parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
    parameter int unsigned H_BP     = VGA_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
    parameter int unsigned V_FP     = VGA_640X480_60.v_fp,
    parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
    parameter int unsigned V_BP     = VGA_640X480_60.v_bp,
    parameter bit          HS_POL   = VGA_640X480_60.hs_pol,
    parameter bit          VS_POL   = VGA_640X480_60.vs_pol,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned CW       = 4
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [3*CW-1:0]    rgb_in,
    output logic               pix_ce,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               fetch_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CW-1:0]      r,
    output logic [CW-1:0]      g,
    output logic [CW-1:0]      b,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [7:0]         frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_VBLANK = COORD_W'(V_ACTIVE);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("vga_scan_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
    end
    if (CLK_DIV < 1 || PIPE_LAT < 1) begin : g_bad_div_lat
        $error("vga_scan_gen: CLK_DIV and PIPE_LAT must both be at least 1");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [7:0]         fcnt_q, fcnt_d;
    logic [3*CW-1:0]    rgb_q, rgb_d;

    sync_bits_t raw_bits, pre_bits, out_bits;

    // Pixel-rate divider: pix_ce marks the last clk of each pixel period.
    always_comb begin
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    assign pix_ce = clrn && (div_q == DIV_LAST);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        fcnt_d = fcnt_q;
        if (pix_ce) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d    = '0;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    y_d = y_q + COORD_W'(1);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    assign raw_bits.hs = in_window(x_q, H_ACTIVE + H_FP, H_SYNC);
    assign raw_bits.vs = in_window(y_q, V_ACTIVE + V_FP, V_SYNC);
    assign raw_bits.de = in_window(x_q, 0, H_ACTIVE) && in_window(y_q, 0, V_ACTIVE);

    vga_sync_delay #(
        .WIDTH ($bits(sync_bits_t)),
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk_i   (clk),
        .rst_ni  (clrn),
        .ce_i    (pix_ce),
        .d_i     (raw_bits),
        .q_o     (out_bits),
        .q_pre_o (pre_bits)
    );

    // Colour is captured on the same strobe that moves pre_bits.de to the output stage.
    always_comb begin
        rgb_d = rgb_q;
        if (pix_ce) begin
            rgb_d = pre_bits.de ? rgb_in : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            div_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            fcnt_q <= '0;
            rgb_q  <= '0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            fcnt_q <= fcnt_d;
            rgb_q  <= rgb_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign fetch_en  = raw_bits.de;
    assign frame_cnt = fcnt_q;

    assign hsync = out_bits.hs ? HS_POL : ~HS_POL;
    assign vsync = out_bits.vs ? VS_POL : ~VS_POL;
    assign de    = out_bits.de;

    assign r = rgb_q[3*CW-1:2*CW];
    assign g = rgb_q[2*CW-1:CW];
    assign b = rgb_q[CW-1:0];

    assign frame_start  = pix_ce && (x_q == '0) && (y_q == '0);
    assign vblank_start = pix_ce && (x_q == '0) && (y_q == Y_VBLANK);

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a tiny raster, long enough to wrap frame_cnt.
module tb_vga_scan_gen;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int D  = 2;
    localparam int PL = 2;
    localparam int CW = 4;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int TOTAL = 46000;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic [11:0]   rgb_in = '0;
    logic          pix_ce, fetch_en, hsync, vsync, de, frame_start, vblank_start;
    logic [9:0]    x, y;
    logic [CW-1:0] r, g, b;
    logic [7:0]    frame_cnt;

    vga_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .CLK_DIV(D), .PIPE_LAT(PL), .CW(CW)
    ) dut (
        .clk(clk), .clrn(clrn), .rgb_in(rgb_in), .pix_ce(pix_ce), .x(x), .y(y),
        .fetch_en(fetch_en), .hsync(hsync), .vsync(vsync), .de(de),
        .r(r), .g(g), .b(b), .frame_start(frame_start), .vblank_start(vblank_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix_ce; int x; int y; int fetch_en; int hsync; int vsync; int de;
        int rgb; int fs; int vb; int fcnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference rules in terms of pixel-tick index n since reset.
    function automatic int px(input int n); return n % HT; endfunction
    function automatic int py(input int n); return (n / HT) % VT; endfunction
    function automatic bit fetch_at(input int n);
        return (px(n) < HA) && (py(n) < VA);
    endfunction
    function automatic bit hs_at(input int n);
        return (px(n) >= HA + HF) && (px(n) < HA + HF + HS);
    endfunction
    function automatic bit vs_at(input int n);
        return (py(n) >= VA + VF) && (py(n) < VA + VF + VS);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Stimulus + model: m counts clk edges since the last reset edge.
    initial begin
        int m;
        int n;
        int n_new;
        bit rst;
        bit mid_done;
        bit late_done;
        bit act;
        logic [11:0] rgb_m;
        exp_t e;
        m = 0; rgb_m = '0; mid_done = 0; late_done = 0;
        for (int cyc = 0; cyc < TOTAL; cyc++) begin
            @(negedge clk);
            n = m / D;
            rst = (cyc < 4);
            if (!mid_done && cyc >= 4 && n / FRAME == 2 && px(n) == 5 && py(n) == 2) begin
                rst = 1; mid_done = 1;
            end
            if (cyc > 4 && cyc < 1500 && $urandom_range(0, 499) == 0) rst = 1;
            if (!late_done && cyc >= TOTAL - 300 && px(n) == 3 && py(n) == 1) begin
                rst = 1; late_done = 1;
            end
            rgb_in = 12'($urandom);
            clrn = !rst;
            if (rst) begin
                m = 0;
                rgb_m = '0;
            end else begin
                if (m % D == D - 1) begin
                    n_new = m / D + 1;
                    rgb_m = (n_new >= PL && fetch_at(n_new - PL)) ? rgb_in : 12'h000;
                end
                m++;
            end
            n = m / D;
            e.pix_ce   = (!rst && (m % D == D - 1)) ? 1 : 0;
            e.x        = px(n);
            e.y        = py(n);
            e.fetch_en = int'(fetch_at(n));
            act        = (n >= PL) && hs_at(n - PL);
            e.hsync    = int'(HSP ? act : !act);
            act        = (n >= PL) && vs_at(n - PL);
            e.vsync    = int'(VSP ? act : !act);
            e.de       = int'((n >= PL) && fetch_at(n - PL));
            e.rgb      = int'(rgb_m);
            e.fs       = int'(e.pix_ce == 1 && e.x == 0 && e.y == 0);
            e.vb       = int'(e.pix_ce == 1 && e.x == 0 && e.y == VA);
            e.fcnt     = (n / FRAME) % 256;
            q.push_back(e);
        end
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        check("late_reset_taken", int'(late_done), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: compares DUT state just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pix_ce", int'(pix_ce), e.pix_ce);
                check("x", int'(x), e.x);
                check("y", int'(y), e.y);
                check("fetch_en", int'(fetch_en), e.fetch_en);
                check("hsync", int'(hsync), e.hsync);
                check("vsync", int'(vsync), e.vsync);
                check("de", int'(de), e.de);
                check("rgb", int'({r, g, b}), e.rgb);
                check("frame_start", int'(frame_start), e.fs);
                check("vblank_start", int'(vblank_start), e.vb);
                check("frame_cnt", int'(frame_cnt), e.fcnt);
            end
        end
    end

endmodule
